// File: rtl/mesm6_ifetch_pkg.sv
// Shared types and helpers for the MESM-6 instruction fetch unit.
// Covers the FSM state encoding, index/tag width helpers and half-word selection.
package mesm6_ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEMAND   = 2'd1,
        PREFETCH = 2'd2
    } state_t;

    // Widest instruction word the half-word selector accepts.
    localparam int MAX_WORD_W = 128;
    localparam int MAX_HALF_W = MAX_WORD_W / 2;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tag_width(input int addr_w, input int depth);
        return addr_w - $clog2(depth);
    endfunction

    // lo=0 picks the upper half of the word, lo=1 the lower half.
    function automatic logic [MAX_HALF_W-1:0] half_select(input logic [MAX_WORD_W-1:0] word,
                                                          input int half_w,
                                                          input logic lo);
        logic [MAX_WORD_W-1:0] mask;
        logic [MAX_WORD_W-1:0] sel;
        mask = ~({MAX_WORD_W{1'b1}} << half_w);
        sel  = lo ? word : (word >> half_w);
        return MAX_HALF_W'(sel & mask);
    endfunction

endpackage

// File: rtl/mesm6_ifetch_store.sv
// Direct-mapped line store: data/tag/valid arrays with one synchronous write port
// and combinational read ports. The second read port exists only with MESM6_IFETCH_PREFETCH_EN.
module mesm6_ifetch_store #(
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2,
    parameter int TAG_W  = 13,
    parameter int WORD_W = 48
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid
`ifdef MESM6_IFETCH_PREFETCH_EN
    ,
    input  logic [IDX_W-1:0]  nx_idx,
    output logic [TAG_W-1:0]  nx_tag,
    output logic              nx_valid
`endif
);

    logic [WORD_W-1:0] data [DEPTH];
    logic [TAG_W-1:0]  tag  [DEPTH];
    logic [DEPTH-1:0]  valid;

    // Clear dominates a same-edge write so flushed fetch data never becomes visible.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[wr_idx] <= wr_data;
            tag[wr_idx]  <= wr_tag;
        end
    end

    assign rd_data  = data[rd_idx];
    assign rd_tag   = tag[rd_idx];
    assign rd_valid = valid[rd_idx];

`ifdef MESM6_IFETCH_PREFETCH_EN
    assign nx_tag   = tag[nx_idx];
    assign nx_valid = valid[nx_idx];
`endif

endmodule

// File: rtl/mesm6_ifetch.sv
// MESM-6 instruction fetch: direct-mapped word cache with demand fill and,
// when MESM6_IFETCH_PREFETCH_EN is defined, sequential next-word prefetch.
module mesm6_ifetch
    import mesm6_ifetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 15,
    parameter int WORD_W = 48
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W:0]     pc,
    input  logic                req,
    input  logic                flush,
    output logic                op_valid,
    output logic [WORD_W/2-1:0] opcode,
    output logic                ibus_fetch,
    output logic [ADDR_W-1:0]   ibus_addr,
    input  logic [WORD_W-1:0]   ibus_input,
    input  logic                ibus_done
);

    localparam int IDX_W  = idx_width(DEPTH);
    localparam int TAG_W  = tag_width(ADDR_W, DEPTH);
    localparam int HALF_W = WORD_W / 2;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              discard;
    logic              discard_nxt;
    logic              wr_en;

    logic [ADDR_W-1:0]     word;
    logic [WORD_W-1:0]     rd_data;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid;
    logic                  hit;
    logic                  want_prefetch;
    logic [MAX_HALF_W-1:0] half;

    assign word = pc[ADDR_W:1];

`ifdef MESM6_IFETCH_PREFETCH_EN
    logic [ADDR_W-1:0] nx_word;
    logic [TAG_W-1:0]  nx_tag;
    logic              nx_valid;
    logic              nx_hit;

    // Natural ADDR_W-bit overflow gives the wrap from the last word to word 0.
    assign nx_word       = word + ADDR_W'(1);
    assign nx_hit        = nx_valid && (nx_tag == nx_word[ADDR_W-1:IDX_W]);
    assign want_prefetch = req && hit && !nx_hit;
`else
    assign want_prefetch = 1'b0;
`endif

    mesm6_ifetch_store #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .WORD_W (WORD_W)
    ) u_store (
        .clk      (clk),
        .clear    (reset | flush),
        .wr_en    (wr_en),
        .wr_idx   (ibus_addr[IDX_W-1:0]),
        .wr_tag   (ibus_addr[ADDR_W-1:IDX_W]),
        .wr_data  (ibus_input),
        .rd_idx   (word[IDX_W-1:0]),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid)
`ifdef MESM6_IFETCH_PREFETCH_EN
        ,
        .nx_idx   (nx_word[IDX_W-1:0]),
        .nx_tag   (nx_tag),
        .nx_valid (nx_valid)
`endif
    );

    assign hit        = rd_valid && (rd_tag == word[ADDR_W-1:IDX_W]);
    assign op_valid   = req && hit;
    assign half       = half_select(MAX_WORD_W'(rd_data), HALF_W, pc[0]);
    assign opcode     = half[HALF_W-1:0];
    assign ibus_fetch = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ibus_addr <= '0;
            discard   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ibus_addr <= addr_nxt;
            discard   <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = ibus_addr;
        discard_nxt = discard;
        wr_en       = 1'b0;
        case (state)
            IDLE: begin
                discard_nxt = 1'b0;
                if (req && !hit) begin
                    addr_nxt  = word;
                    state_nxt = DEMAND;
                end else if (want_prefetch) begin
`ifdef MESM6_IFETCH_PREFETCH_EN
                    addr_nxt  = nx_word;
                    state_nxt = PREFETCH;
`endif
                end
            end
            default: begin
                // A flush seen at any point of the bus cycle poisons its returned data.
                if (flush) begin
                    discard_nxt = 1'b1;
                end
                if (ibus_done) begin
                    wr_en     = !discard && !flush;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mesm6_ifetch.sv
// Self-checking bench for mesm6_ifetch: table-driven hit/miss vectors plus
// hand-written flush, reset and prefetch sequences against a memory model.
module tb_mesm6_ifetch;

    localparam int ADDR_W = 15;
    localparam int WORD_W = 48;
    localparam int DEPTH  = 4;
`ifdef MESM6_IFETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W:0]   pc = '0;
    logic              req = 1'b0;
    logic              flush = 1'b0;
    logic              op_valid;
    logic [23:0]       opcode;
    logic              ibus_fetch;
    logic [ADDR_W-1:0] ibus_addr;
    logic [WORD_W-1:0] ibus_input;
    logic              ibus_done;

    int checks = 0;
    int errors = 0;

    bit                auto_bus = 1'b1;
    int                wait_cycles = 1;
    bit                man_done = 1'b0;
    logic [ADDR_W-1:0] man_addr = '0;
    logic [ADDR_W-1:0] fetch_log[$];
    int                fetch_cyc = 0;
    logic [23:0]       exp_q[$];

    typedef struct {
        logic [ADDR_W:0] pc;
        int              wt;
        bit              hit;
    } vec_t;
    vec_t tbl[8];

    mesm6_ifetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .req        (req),
        .flush      (flush),
        .op_valid   (op_valid),
        .opcode     (opcode),
        .ibus_fetch (ibus_fetch),
        .ibus_addr  (ibus_addr),
        .ibus_input (ibus_input),
        .ibus_done  (ibus_done)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {9'h155, a, 9'h0AA, ~a};
    endfunction

    // Bus responder: auto mode answers after wait_cycles, manual mode follows man_done.
    initial begin
        int wcnt;
        wcnt = 0;
        ibus_done = 1'b0;
        ibus_input = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!auto_bus) begin
                ibus_done = man_done;
                ibus_input = mem_word(man_addr);
                wcnt = 0;
            end else if (reset) begin
                ibus_done = 1'b0;
                wcnt = 0;
            end else if (ibus_done) begin
                ibus_done = 1'b0;
            end else if (ibus_fetch) begin
                if (wcnt >= wait_cycles) begin
                    ibus_done = 1'b1;
                    ibus_input = mem_word(ibus_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && ibus_fetch) begin
                fetch_cyc++;
                if (ibus_done) fetch_log.push_back(ibus_addr);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_log(input string nm, input logic [ADDR_W-1:0] exp[$]);
        chk({nm, "_count"}, 64'(fetch_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < fetch_log.size(); i++)
            chk($sformatf("%s_addr%0d", nm, i), 64'(fetch_log[i]), 64'(exp[i]));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 1'b0;
        flush = 1'b0;
        man_done = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        req = 1'b0;
        @(negedge clk);
        while (ibus_fetch && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (ibus_fetch) begin
            checks++;
            errors++;
            $display("FAIL settle ibus_fetch still 1 required 0 within 60 cycles");
        end
        cyc();
    endtask

    task automatic access(input logic [ADDR_W:0] a, input int lat, input string nm, input bit pre);
        logic [WORD_W-1:0] w;
        logic [23:0] e;
        int n;
        bit seen;
        if (pre) settle();
        w = mem_word(a[ADDR_W:1]);
        exp_q.push_back(a[0] ? w[23:0] : w[47:24]);
        pc = a;
        req = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (op_valid) seen = 1'b1;
            else begin
                cyc();
                n++;
            end
        end
        e = exp_q.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s op_valid never rose, required after %0d cycles", nm, lat);
        end else begin
            chk({nm, "_opcode"}, 64'(opcode), 64'(e));
            chk({nm, "_latency"}, 64'(n), 64'(lat));
        end
        cyc();
        req = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] el[$];

        tbl[0] = '{pc: 16'd8,  wt: 1, hit: 1'b0};
        tbl[1] = '{pc: 16'd9,  wt: 1, hit: 1'b1};
        tbl[2] = '{pc: 16'd4,  wt: 0, hit: 1'b0};
        tbl[3] = '{pc: 16'd5,  wt: 0, hit: 1'b1};
        tbl[4] = '{pc: 16'd8,  wt: 0, hit: 1'b1};
        tbl[5] = '{pc: 16'd24, wt: 2, hit: 1'b0};
        tbl[6] = '{pc: 16'd8,  wt: 3, hit: 1'b0};
        tbl[7] = '{pc: 16'd25, wt: 1, hit: 1'b0};

        // Reset state, with req high and nothing cached.
        reset = 1'b1;
        req = 1'b1;
        pc = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_op_valid", 64'(op_valid), 64'd0);
        chk("rst_ibus_fetch", 64'(ibus_fetch), 64'd0);
        chk("rst_ibus_addr", 64'(ibus_addr), 64'd0);

        // First fill of word 0, then its low half hits without a bus cycle.
        do_reset();
        wait_cycles = 1;
        fetch_cyc = 0;
        fetch_log.delete();
        access(16'h0000, 3, "word0_hi", 1'b1);
        access(16'h0001, 0, "word0_lo", 1'b1);
        settle();
        chk("word0_fetch_cycles", 64'(fetch_cyc), PF ? 64'd4 : 64'd2);
        el.delete();
        el.push_back(15'd0);
        if (PF) el.push_back(15'd1);
        chk_log("word0_bus", el);

        // Table of hit/miss vectors with varying bus wait states.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wait_cycles = tbl[i].wt;
            access(tbl[i].pc, tbl[i].hit ? 0 : tbl[i].wt + 2, $sformatf("vec%0d", i), 1'b1);
        end

        // Conflict eviction: word 5 replaces word 1 in line 1.
        do_reset();
        wait_cycles = 1;
        access(16'd2, 3, "evict_w1", 1'b1);
        access(16'd10, 3, "evict_w5", 1'b1);
        settle();
        fetch_log.delete();
        access(16'd2, 3, "evict_w1_again", 1'b1);
        settle();
        el.delete();
        el.push_back(15'd1);
        if (PF) el.push_back(15'd2);
        chk_log("evict_bus", el);

        // Flush in the same cycle as ibus_done for word 3.
        do_reset();
        auto_bus = 1'b0;
        pc = 16'd6;
        req = 1'b1;
        cyc();
        req = 1'b0;
        @(negedge clk);
        chk("flushdone_fetch", 64'(ibus_fetch), 64'd1);
        chk("flushdone_addr", 64'(ibus_addr), 64'd3);
        cyc();
        man_addr = 15'd3;
        man_done = 1'b1;
        flush = 1'b1;
        cyc();
        man_done = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flushdone_idle", 64'(ibus_fetch), 64'd0);
        cyc();
        auto_bus = 1'b1;
        fetch_log.delete();
        access(16'd6, 3, "flushdone_refetch", 1'b1);
        settle();
        el.delete();
        el.push_back(15'd3);
        if (PF) el.push_back(15'd4);
        chk_log("flushdone_bus", el);

        // Flush mid-fetch, done arriving later, for word 7.
        auto_bus = 1'b0;
        pc = 16'd14;
        req = 1'b1;
        cyc();
        req = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        man_addr = 15'd7;
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        cyc();
        auto_bus = 1'b1;
        fetch_log.delete();
        access(16'd14, 3, "flushmid_refetch", 1'b1);
        settle();
        el.delete();
        el.push_back(15'd7);
        if (PF) el.push_back(15'd8);
        chk_log("flushmid_bus", el);

        // Hit at word 5: sequential prefetch of word 6.
        do_reset();
        wait_cycles = 1;
        fetch_log.delete();
        access(16'd10, 3, "seq_w5", 1'b1);
        settle();
        el.delete();
        el.push_back(15'd5);
        if (PF) el.push_back(15'd6);
        chk_log("seq_bus", el);
        access(16'h000C, PF ? 0 : 3, "seq_w6", 1'b1);

        // Prefetch address wraps from the top word to word 0.
        do_reset();
        fetch_log.delete();
        access(16'hFFFE, 3, "wrap_top", 1'b1);
        settle();
        el.delete();
        el.push_back(15'h7FFF);
        if (PF) el.push_back(15'h0000);
        chk_log("wrap_bus", el);
        access(16'h0000, PF ? 0 : 3, "wrap_w0", 1'b1);

        // Demand for word 9 while its prefetch is already on the bus.
        do_reset();
        wait_cycles = 3;
        access(16'd16, 5, "inflight_w8", 1'b1);
        fetch_log.delete();
        access(16'd18, PF ? 4 : 5, "inflight_w9", 1'b0);
        settle();
        el.delete();
        el.push_back(15'd9);
        if (PF) el.push_back(15'd10);
        chk_log("inflight_bus", el);

        // Reset while a fetch is outstanding; the late done must be ignored.
        do_reset();
        auto_bus = 1'b0;
        pc = 16'd20;
        req = 1'b1;
        cyc();
        req = 1'b0;
        @(negedge clk);
        chk("rstmid_fetch_before", 64'(ibus_fetch), 64'd1);
        chk("rstmid_addr_before", 64'(ibus_addr), 64'd10);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_fetch_after", 64'(ibus_fetch), 64'd0);
        chk("rstmid_addr_after", 64'(ibus_addr), 64'd0);
        cyc();
        man_addr = 15'd10;
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        req = 1'b1;
        @(negedge clk);
        chk("rstmid_not_valid", 64'(op_valid), 64'd0);
        #1;
        req = 1'b0;
        cyc();
        auto_bus = 1'b1;
        wait_cycles = 1;
        fetch_log.delete();
        access(16'd20, 3, "rstmid_refetch", 1'b1);
        settle();
        el.delete();
        el.push_back(15'd10);
        if (PF) el.push_back(15'd11);
        chk_log("rstmid_bus", el);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
